// File: rtl/ahb_timer_led_slave.sv
// AHB-Lite slave: reloadable 32-bit down-counter with underflow flag,
// interrupt request and a firmware-controlled LED output.
module ahb_timer_led_slave #(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] RELOAD_RST = 32'd26999999
) (
  input  logic              sysclk,
  input  logic              RSTn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              led,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam int WW = ADDR_W - 2;

  state_t state;
  state_t state_n;

  logic          acc;
  logic          legal;
  logic          acc_ok;
  logic          acc_bad;
  logic [WW-1:0] word;

  logic       dp_valid;
  logic       dp_write;
  logic [2:0] dp_idx;

  logic wr;
  logic wr_ctrl;
  logic wr_reload;
  logic wr_value;
  logic wr_status;
  logic wr_led;
  logic rd;

  logic [3:0]  ctrl;
  logic [31:0] reload;
  logic [31:0] value;
  logic        uf;
  logic        led_q;

  logic en;
  logic ie;
  logic auto_rl;
  logic ledtog;
  logic hit;

  logic unused_ok;

  assign unused_ok = HTRANS[0];

  // Address phase decode
  assign acc     = HSEL & HREADY & HTRANS[1];
  assign word    = HADDR[ADDR_W-1:2];
  assign legal   = (HSIZE == 3'b010)
                 & (HADDR[1:0] == 2'b00)
                 & (word < WW'(5));
  assign acc_ok  = acc & legal;
  assign acc_bad = acc & ~legal;

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= 3'd0;
    end else if (HREADY) begin
      dp_valid <= acc_ok;
      dp_write <= HWRITE;
      dp_idx   <= HADDR[4:2];
    end else begin
      dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Two-cycle ERROR; a new transfer may start in ERR2
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (acc_bad) begin
          state_n = S_ERR1;
        end
      end
      S_ERR1: begin
        state_n = S_ERR2;
      end
      S_ERR2: begin
        state_n = acc_bad ? S_ERR1 : S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign HREADYOUT = (state != S_ERR1);
  assign HRESP     = (state != S_IDLE);

  assign wr        = dp_valid & dp_write;
  assign rd        = dp_valid & ~dp_write;
  assign wr_ctrl   = wr & (dp_idx == 3'd0);
  assign wr_reload = wr & (dp_idx == 3'd1);
  assign wr_value  = wr & (dp_idx == 3'd2);
  assign wr_status = wr & (dp_idx == 3'd3);
  assign wr_led    = wr & (dp_idx == 3'd4);

  assign en      = ctrl[0];
  assign ie      = ctrl[1];
  assign auto_rl = ctrl[2];
  assign ledtog  = ctrl[3];
  assign hit     = en & (value == 32'd0);

  // Bus writes take priority over hardware updates, except UF set
  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      ctrl <= 4'd0;
    end else if (wr_ctrl) begin
      ctrl <= HWDATA[3:0];
    end else if (hit & ~auto_rl) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      reload <= RELOAD_RST;
    end else if (wr_reload) begin
      reload <= HWDATA;
    end
  end

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      value <= 32'd0;
    end else if (wr_value) begin
      value <= HWDATA;
    end else if (en) begin
      if (value != 32'd0) begin
        value <= value - 32'd1;
      end else if (auto_rl) begin
        value <= reload;
      end
    end
  end

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      uf <= 1'b0;
    end else if (hit) begin
      uf <= 1'b1;
    end else if (wr_status & HWDATA[0]) begin
      uf <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      led_q <= 1'b0;
    end else if (wr_led) begin
      led_q <= HWDATA[0];
    end else if (hit & ledtog) begin
      led_q <= ~led_q;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd) begin
      unique case (1'b1)
        (dp_idx == 3'd0): HRDATA = {28'd0, ctrl};
        (dp_idx == 3'd1): HRDATA = reload;
        (dp_idx == 3'd2): HRDATA = value;
        (dp_idx == 3'd3): HRDATA = {31'd0, uf};
        (dp_idx == 3'd4): HRDATA = {31'd0, led_q};
        default:          HRDATA = 32'd0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = uf & ie;

endmodule

// File: tb/tb_ahb_timer_led_slave.sv
// Directed bench for ahb_timer_led_slave: register access, counter
// modes, error responses and write/hardware collisions.
module tb_ahb_timer_led_slave;

  logic        sysclk;
  logic        RSTn;
  logic        HSEL;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        led;
  logic        irq;

  int tests;
  int fails;

  ahb_timer_led_slave dut (
    .sysclk    (sysclk),
    .RSTn      (RSTn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .led       (led),
    .irq       (irq)
  );

  assign HREADY = HREADYOUT;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
  endtask

  task automatic ahb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge sysclk); #1;
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10;
    HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge sysclk); #1;
    bus_idle();
    HWDATA = d;
    @(posedge sysclk); #1;
  endtask

  task automatic ahb_read(input logic [11:0] a, output logic [31:0] d,
                          output logic rdy, output logic rsp);
    @(posedge sysclk); #1;
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10;
    HWRITE = 1'b0; HSIZE = 3'b010;
    @(posedge sysclk); #1;
    bus_idle();
    d   = HRDATA;
    rdy = HREADYOUT;
    rsp = HRESP;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v [5];
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    exp_v = '{32'd0, 32'd26999999, 32'd0, 32'd0, 32'd0};
    RSTn = 1'b0;
    bus_idle();
    HADDR = '0;
    HWDATA = '0;
    #22;
    tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'd0) begin
      fails++;
      $display("FAIL reset_bus: rdy=%b rsp=%b rdata=%h want 1 0 0",
               HREADYOUT, HRESP, HRDATA);
    end
    tests++;
    if (led !== 1'b0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: led=%b irq=%b want 0 0", led, irq);
    end
    @(negedge sysclk);
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ahb_read(12'(i * 4), d, rdy, rsp);
      tests++;
      if (d !== exp_v[i] || rdy !== 1'b1 || rsp !== 1'b0) begin
        fails++;
        $display("FAIL reset_reg%0d: got %0d rdy=%b rsp=%b want %0d 1 0",
                 i, d, rdy, rsp, exp_v[i]);
      end
    end
  endtask

  task automatic test_auto();
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    ahb_write(12'h004, 32'd4);
    ahb_write(12'h008, 32'd4);
    ahb_write(12'h000, 32'hF);
    // toggles after the 5th, 10th and 15th enabled edge
    for (int i = 1; i <= 15; i++) begin
      @(posedge sysclk); #1;
      tests++;
      if (led !== 1'((i / 5) % 2) || irq !== (i >= 5)) begin
        fails++;
        $display("FAIL auto_cyc%0d: led=%b irq=%b want %b %b",
                 i, led, irq, 1'((i / 5) % 2), (i >= 5));
      end
    end
    ahb_write(12'h000, 32'd0);
    ahb_read(12'h008, d, rdy, rsp);
    tests++;
    if (d !== 32'd1) begin
      fails++;
      $display("FAIL auto_stop_value: got %0d want 1", d);
    end
    ahb_write(12'h00C, 32'd1);
    ahb_write(12'h010, 32'd0);
    ahb_read(12'h00C, d, rdy, rsp);
    tests++;
    if (d !== 32'd0 || irq !== 1'b0 || led !== 1'b0) begin
      fails++;
      $display("FAIL auto_clear: status=%0d irq=%b led=%b want 0 0 0",
               d, irq, led);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    ahb_write(12'h008, 32'd3);
    ahb_write(12'h000, 32'h1);
    repeat (3) @(posedge sysclk);
    #1;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL oneshot_irq: got %b want 0", irq);
    end
    @(posedge sysclk); #1;
    ahb_read(12'h00C, d, rdy, rsp);
    tests++;
    if (d !== 32'd1) begin
      fails++;
      $display("FAIL oneshot_uf: got %0d want 1", d);
    end
    ahb_read(12'h008, d, rdy, rsp);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL oneshot_value: got %0d want 0", d);
    end
    ahb_read(12'h000, d, rdy, rsp);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL oneshot_ctrl: got %h want 0", d);
    end
    ahb_write(12'h00C, 32'd1);
    ahb_read(12'h00C, d, rdy, rsp);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL oneshot_w1c: got %0d want 0", d);
    end
  endtask

  task automatic test_error();
    logic [11:0] ea [3];
    logic        ew [3];
    logic [2:0]  es [3];
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    ea = '{12'h014, 12'h004, 12'h006};
    ew = '{1'b0, 1'b1, 1'b1};
    es = '{3'b010, 3'b000, 3'b010};
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclk); #1;
      HSEL = 1'b1; HADDR = ea[i]; HTRANS = 2'b10;
      HWRITE = ew[i]; HSIZE = es[i];
      @(posedge sysclk); #1;
      bus_idle();
      HWDATA = 32'hDEADBEEF;
      tests++;
      if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'd0) begin
        fails++;
        $display("FAIL err%0d_c1: rdy=%b rsp=%b rdata=%h want 0 1 0",
                 i, HREADYOUT, HRESP, HRDATA);
      end
      @(posedge sysclk); #1;
      tests++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
        fails++;
        $display("FAIL err%0d_c2: rdy=%b rsp=%b want 1 1",
                 i, HREADYOUT, HRESP);
      end
      @(posedge sysclk); #1;
      tests++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
        fails++;
        $display("FAIL err%0d_end: rdy=%b rsp=%b want 1 0",
                 i, HREADYOUT, HRESP);
      end
    end
    ahb_read(12'h004, d, rdy, rsp);
    tests++;
    if (d !== 32'd4 || rdy !== 1'b1 || rsp !== 1'b0) begin
      fails++;
      $display("FAIL err_reload: got %0d want 4", d);
    end
  endtask

  task automatic test_value_race();
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    ahb_write(12'h004, 32'd50);
    ahb_write(12'h008, 32'd3);
    ahb_write(12'h000, 32'h5);
    // VALUE write lands on the edge where the counter sits at 0
    @(posedge sysclk); #1;
    ahb_write(12'h008, 32'd100);
    ahb_read(12'h008, d, rdy, rsp);
    tests++;
    if (d !== 32'd98) begin
      fails++;
      $display("FAIL race_value: got %0d want 98", d);
    end
    ahb_write(12'h000, 32'd0);
    ahb_write(12'h00C, 32'd1);
  endtask

  task automatic test_back_to_back();
    @(posedge sysclk); #1;
    HSEL = 1'b1; HADDR = 12'h004; HTRANS = 2'b10;
    HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge sysclk); #1;
    tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      fails++;
      $display("FAIL b2b_wr: rdy=%b rsp=%b want 1 0", HREADYOUT, HRESP);
    end
    HWDATA = 32'h0000_1234;
    HADDR = 12'h004; HTRANS = 2'b10; HWRITE = 1'b0;
    @(posedge sysclk); #1;
    bus_idle();
    tests++;
    if (HRDATA !== 32'h1234 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      fails++;
      $display("FAIL b2b_rd: got %h rdy=%b rsp=%b want 1234 1 0",
               HRDATA, HREADYOUT, HRESP);
    end
  endtask

  task automatic test_reset_mid_error();
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    @(posedge sysclk); #1;
    HSEL = 1'b1; HADDR = 12'h020; HTRANS = 2'b10;
    HWRITE = 1'b0; HSIZE = 3'b010;
    @(posedge sysclk); #1;
    bus_idle();
    tests++;
    if (HREADYOUT !== 1'b0) begin
      fails++;
      $display("FAIL rme_err1: rdy=%b want 0", HREADYOUT);
    end
    RSTn = 1'b0;
    #1;
    tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      fails++;
      $display("FAIL rme_async: rdy=%b rsp=%b want 1 0", HREADYOUT, HRESP);
    end
    @(negedge sysclk);
    RSTn = 1'b1;
    ahb_read(12'h004, d, rdy, rsp);
    tests++;
    if (d !== 32'd26999999 || rdy !== 1'b1 || rsp !== 1'b0) begin
      fails++;
      $display("FAIL rme_reload: got %0d rdy=%b rsp=%b want 26999999 1 0",
               d, rdy, rsp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_auto();
    test_oneshot();
    test_error();
    test_value_race();
    test_back_to_back();
    test_reset_mid_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
